// File: rtl/axil_fifo_csr_shell.sv
// axil_fifo_csr_shell
// AXI4-Lite slave shell. Software sees four 256-byte regions:
//   0x000 PS->PL FIFO push / free-slot count
//   0x100 PL->PS FIFO pop
//   0x200 PL->PS FIFO occupancy
//   0x300 byte-maskable R/W CSRs
// Unmapped slots answer SLVERR and have no side effects.

module axil_fifo_csr_shell_chk #(
    parameter int num_in_fifos_p = 2
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [num_in_fifos_p-1:0] in_v_o,
    input  logic [num_in_fifos_p-1:0] in_yumi_i
);
    // The PL must never dequeue from an empty PS->PL FIFO
    always_ff @(posedge aclk) begin
        if (aresetn) begin
            assert ((in_yumi_i & ~in_v_o) == '0);
        end
    end
endmodule

module axil_fifo_csr_shell #(
    parameter int num_regs_p         = 4,
    parameter int num_in_fifos_p     = 2,
    parameter int num_out_fifos_p    = 2,
    parameter int fifo_els_p         = 4,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 10
) (
    input  logic                                      aclk,
    input  logic                                      aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]             s_axi_awaddr,
    input  logic [2:0]                                s_axi_awprot,
    input  logic                                      s_axi_awvalid,
    output logic                                      s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]             s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]           s_axi_wstrb,
    input  logic                                      s_axi_wvalid,
    output logic                                      s_axi_wready,
    output logic [1:0]                                s_axi_bresp,
    output logic                                      s_axi_bvalid,
    input  logic                                      s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]             s_axi_araddr,
    input  logic [2:0]                                s_axi_arprot,
    input  logic                                      s_axi_arvalid,
    output logic                                      s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]             s_axi_rdata,
    output logic [1:0]                                s_axi_rresp,
    output logic                                      s_axi_rvalid,
    input  logic                                      s_axi_rready,
    output logic [C_S_AXI_DATA_WIDTH*num_regs_p-1:0]      csr_data_o,
    output logic [num_in_fifos_p-1:0]                     in_v_o,
    output logic [C_S_AXI_DATA_WIDTH*num_in_fifos_p-1:0]  in_data_o,
    input  logic [num_in_fifos_p-1:0]                     in_yumi_i,
    input  logic [num_out_fifos_p-1:0]                    out_v_i,
    input  logic [C_S_AXI_DATA_WIDTH*num_out_fifos_p-1:0] out_data_i,
    output logic [num_out_fifos_p-1:0]                    out_ready_o
);
    localparam int dw_lp    = C_S_AXI_DATA_WIDTH;
    localparam int sw_lp    = dw_lp / 8;
    localparam int ptr_w_lp = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
    localparam int cnt_w_lp = $clog2(fifo_els_p + 1);
    localparam logic [cnt_w_lp-1:0] fifo_els_lp = cnt_w_lp'(fifo_els_p);

    typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_e;
    typedef enum logic {R_IDLE = 1'b0, R_RESP = 1'b1} r_state_e;

    w_state_e w_state_q, w_state_d;
    r_state_e r_state_q, r_state_d;
    logic [1:0]       bresp_q, bresp_d;
    logic [1:0]       rresp_q, rresp_d;
    logic [dw_lp-1:0] rdata_q, rdata_d;

    logic [dw_lp-1:0]    csr_q        [num_regs_p];
    logic [dw_lp-1:0]    csr_d        [num_regs_p];
    logic [dw_lp-1:0]    in_mem_q     [num_in_fifos_p][fifo_els_p];
    logic [dw_lp-1:0]    in_mem_d     [num_in_fifos_p][fifo_els_p];
    logic [ptr_w_lp-1:0] in_wr_ptr_q  [num_in_fifos_p];
    logic [ptr_w_lp-1:0] in_wr_ptr_d  [num_in_fifos_p];
    logic [ptr_w_lp-1:0] in_rd_ptr_q  [num_in_fifos_p];
    logic [ptr_w_lp-1:0] in_rd_ptr_d  [num_in_fifos_p];
    logic [cnt_w_lp-1:0] in_cnt_q     [num_in_fifos_p];
    logic [cnt_w_lp-1:0] in_cnt_d     [num_in_fifos_p];
    logic [dw_lp-1:0]    out_mem_q    [num_out_fifos_p][fifo_els_p];
    logic [dw_lp-1:0]    out_mem_d    [num_out_fifos_p][fifo_els_p];
    logic [ptr_w_lp-1:0] out_wr_ptr_q [num_out_fifos_p];
    logic [ptr_w_lp-1:0] out_wr_ptr_d [num_out_fifos_p];
    logic [ptr_w_lp-1:0] out_rd_ptr_q [num_out_fifos_p];
    logic [ptr_w_lp-1:0] out_rd_ptr_d [num_out_fifos_p];
    logic [cnt_w_lp-1:0] out_cnt_q    [num_out_fifos_p];
    logic [cnt_w_lp-1:0] out_cnt_d    [num_out_fifos_p];

    logic       wr_fire_s, rd_fire_s, aw_hi_ok_s, ar_hi_ok_s, wr_ok_s, rd_ok_s;
    logic [1:0] aw_region_s, ar_region_s;
    logic [5:0] aw_slot_s, ar_slot_s;
    logic [dw_lp-1:0]           rd_data_s;
    logic [num_in_fifos_p-1:0]  in_full_s, in_empty_s, push_s, in_deq_s;
    logic [num_out_fifos_p-1:0] out_full_s, out_empty_s, pop_s, out_enq_s;
    logic [num_regs_p-1:0]      csr_we_s;

    // Protection bits and byte-lane address bits carry no meaning here
    logic unused_s;
    assign unused_s = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    assign s_axi_awready = wr_fire_s;
    assign s_axi_wready  = wr_fire_s;
    assign s_axi_arready = rd_fire_s;
    assign s_axi_bvalid  = (w_state_q == W_RESP);
    assign s_axi_rvalid  = (r_state_q == R_RESP);
    assign s_axi_bresp   = bresp_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rdata   = rdata_q;

    // FIFO status flags and PL-facing outputs, all decoded from registered state
    always_comb begin
        in_full_s   = '0;
        in_empty_s  = '0;
        out_full_s  = '0;
        out_empty_s = '0;
        in_data_o   = '0;
        csr_data_o  = '0;
        for (int i = 0; i < num_in_fifos_p; i++) begin
            in_full_s[i]             = (in_cnt_q[i] == fifo_els_lp);
            in_empty_s[i]            = (in_cnt_q[i] == '0);
            in_data_o[dw_lp*i +: dw_lp] = in_mem_q[i][in_rd_ptr_q[i]];
        end
        for (int j = 0; j < num_out_fifos_p; j++) begin
            out_full_s[j]  = (out_cnt_q[j] == fifo_els_lp);
            out_empty_s[j] = (out_cnt_q[j] == '0);
        end
        for (int k = 0; k < num_regs_p; k++) begin
            csr_data_o[dw_lp*k +: dw_lp] = csr_q[k];
        end
        in_v_o      = ~in_empty_s;
        out_ready_o = ~out_full_s;
    end

    // Address decode: pick the write/read target, its side effects and response data
    always_comb begin
        aw_region_s = s_axi_awaddr[9:8];
        aw_slot_s   = s_axi_awaddr[7:2];
        aw_hi_ok_s  = ((s_axi_awaddr >> 4'd10) == '0);
        ar_region_s = s_axi_araddr[9:8];
        ar_slot_s   = s_axi_araddr[7:2];
        ar_hi_ok_s  = ((s_axi_araddr >> 4'd10) == '0);
        wr_fire_s   = (w_state_q == W_IDLE) && s_axi_awvalid && s_axi_wvalid;
        rd_fire_s   = (r_state_q == R_IDLE) && s_axi_arvalid;
        push_s      = '0;
        pop_s       = '0;
        csr_we_s    = '0;
        wr_ok_s     = 1'b0;
        rd_ok_s     = 1'b0;
        rd_data_s   = '0;
        for (int i = 0; i < num_in_fifos_p; i++) begin
            // Push succeeds only into a non-full FIFO; free count is read pre-push
            push_s[i] = wr_fire_s && aw_hi_ok_s && (aw_region_s == 2'd0)
                        && (aw_slot_s == 6'(i)) && !in_full_s[i];
            wr_ok_s   = wr_ok_s | (aw_hi_ok_s && (aw_region_s == 2'd0)
                        && (aw_slot_s == 6'(i)) && !in_full_s[i]);
            rd_ok_s   = rd_ok_s | (ar_hi_ok_s && (ar_region_s == 2'd0) && (ar_slot_s == 6'(i)));
            rd_data_s = rd_data_s | ({dw_lp{ar_hi_ok_s && (ar_region_s == 2'd0) && (ar_slot_s == 6'(i))}}
                        & dw_lp'(fifo_els_lp - in_cnt_q[i]));
        end
        for (int j = 0; j < num_out_fifos_p; j++) begin
            // Pop from an empty FIFO leaves rd_ok_s low and returns zero
            pop_s[j]  = rd_fire_s && ar_hi_ok_s && (ar_region_s == 2'd1)
                        && (ar_slot_s == 6'(j)) && !out_empty_s[j];
            rd_ok_s   = rd_ok_s | (ar_hi_ok_s && (ar_region_s == 2'd1)
                        && (ar_slot_s == 6'(j)) && !out_empty_s[j]);
            rd_data_s = rd_data_s | ({dw_lp{ar_hi_ok_s && (ar_region_s == 2'd1)
                        && (ar_slot_s == 6'(j)) && !out_empty_s[j]}} & out_mem_q[j][out_rd_ptr_q[j]]);
            rd_ok_s   = rd_ok_s | (ar_hi_ok_s && (ar_region_s == 2'd2) && (ar_slot_s == 6'(j)));
            rd_data_s = rd_data_s | ({dw_lp{ar_hi_ok_s && (ar_region_s == 2'd2) && (ar_slot_s == 6'(j))}}
                        & dw_lp'(out_cnt_q[j]));
        end
        for (int k = 0; k < num_regs_p; k++) begin
            csr_we_s[k] = wr_fire_s && aw_hi_ok_s && (aw_region_s == 2'd3) && (aw_slot_s == 6'(k));
            wr_ok_s     = wr_ok_s | (aw_hi_ok_s && (aw_region_s == 2'd3) && (aw_slot_s == 6'(k)));
            rd_ok_s     = rd_ok_s | (ar_hi_ok_s && (ar_region_s == 2'd3) && (ar_slot_s == 6'(k)));
            rd_data_s   = rd_data_s | ({dw_lp{ar_hi_ok_s && (ar_region_s == 2'd3)
                          && (ar_slot_s == 6'(k))}} & csr_q[k]);
        end
    end

    // Write channel FSM: accept aw+w together, then hold the response until bready
    always_comb begin
        w_state_d = w_state_q;
        bresp_d   = bresp_q;
        case (w_state_q)
            W_IDLE: begin
                if (wr_fire_s) begin
                    w_state_d = W_RESP;
                    bresp_d   = wr_ok_s ? 2'b00 : 2'b10;
                end else begin
                    w_state_d = W_IDLE;
                end
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    w_state_d = W_IDLE;
                end else begin
                    w_state_d = W_RESP;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Read channel FSM: capture data/response at the arready edge, hold until rready
    always_comb begin
        r_state_d = r_state_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                if (rd_fire_s) begin
                    r_state_d = R_RESP;
                    rdata_d   = rd_data_s;
                    rresp_d   = rd_ok_s ? 2'b00 : 2'b10;
                end else begin
                    r_state_d = R_IDLE;
                end
            end
            R_RESP: begin
                if (s_axi_rready) begin
                    r_state_d = R_IDLE;
                end else begin
                    r_state_d = R_RESP;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // FIFO and CSR next-state: same-cycle enqueue and dequeue leave the count unchanged
    always_comb begin
        in_mem_d     = in_mem_q;
        out_mem_d    = out_mem_q;
        csr_d        = csr_q;
        in_deq_s     = '0;
        out_enq_s    = '0;
        for (int i = 0; i < num_in_fifos_p; i++) begin
            in_deq_s[i]    = in_yumi_i[i] && !in_empty_s[i];
            in_mem_d[i][in_wr_ptr_q[i]] = push_s[i] ? s_axi_wdata : in_mem_q[i][in_wr_ptr_q[i]];
            in_wr_ptr_d[i] = in_wr_ptr_q[i] + ptr_w_lp'(push_s[i]);
            in_rd_ptr_d[i] = in_rd_ptr_q[i] + ptr_w_lp'(in_deq_s[i]);
            in_cnt_d[i]    = in_cnt_q[i] + cnt_w_lp'(push_s[i]) - cnt_w_lp'(in_deq_s[i]);
        end
        for (int j = 0; j < num_out_fifos_p; j++) begin
            out_enq_s[j]    = out_v_i[j] && !out_full_s[j];
            out_mem_d[j][out_wr_ptr_q[j]] = out_enq_s[j] ? out_data_i[dw_lp*j +: dw_lp]
                                                         : out_mem_q[j][out_wr_ptr_q[j]];
            out_wr_ptr_d[j] = out_wr_ptr_q[j] + ptr_w_lp'(out_enq_s[j]);
            out_rd_ptr_d[j] = out_rd_ptr_q[j] + ptr_w_lp'(pop_s[j]);
            out_cnt_d[j]    = out_cnt_q[j] + cnt_w_lp'(out_enq_s[j]) - cnt_w_lp'(pop_s[j]);
        end
        for (int k = 0; k < num_regs_p; k++) begin
            for (int b = 0; b < sw_lp; b++) begin
                csr_d[k][8*b +: 8] = (csr_we_s[k] && s_axi_wstrb[b]) ? s_axi_wdata[8*b +: 8]
                                                                    : csr_q[k][8*b +: 8];
            end
        end
    end

    // State registers with synchronous active-low reset; reset drops any open transaction
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            w_state_q    <= W_IDLE;
            r_state_q    <= R_IDLE;
            bresp_q      <= 2'b00;
            rresp_q      <= 2'b00;
            rdata_q      <= '0;
            csr_q        <= '{default: '0};
            in_mem_q     <= '{default: '{default: '0}};
            in_wr_ptr_q  <= '{default: '0};
            in_rd_ptr_q  <= '{default: '0};
            in_cnt_q     <= '{default: '0};
            out_mem_q    <= '{default: '{default: '0}};
            out_wr_ptr_q <= '{default: '0};
            out_rd_ptr_q <= '{default: '0};
            out_cnt_q    <= '{default: '0};
        end else begin
            w_state_q    <= w_state_d;
            r_state_q    <= r_state_d;
            bresp_q      <= bresp_d;
            rresp_q      <= rresp_d;
            rdata_q      <= rdata_d;
            csr_q        <= csr_d;
            in_mem_q     <= in_mem_d;
            in_wr_ptr_q  <= in_wr_ptr_d;
            in_rd_ptr_q  <= in_rd_ptr_d;
            in_cnt_q     <= in_cnt_d;
            out_mem_q    <= out_mem_d;
            out_wr_ptr_q <= out_wr_ptr_d;
            out_rd_ptr_q <= out_rd_ptr_d;
            out_cnt_q    <= out_cnt_d;
        end
    end

    axil_fifo_csr_shell_chk #(
        .num_in_fifos_p (num_in_fifos_p)
    ) u_chk (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .in_v_o    (in_v_o),
        .in_yumi_i (in_yumi_i)
    );
endmodule

// File: tb/tb_axil_fifo_csr_shell.sv
// Self-checking bench for axil_fifo_csr_shell: expected responses are queued
// when a transaction is issued and compared when the DUT answers.
module tb_axil_fifo_csr_shell;
    localparam int NR = 4, NI = 2, NO = 2, ELS = 4;

    logic        aclk = 1'b0, aresetn = 1'b0;
    logic [9:0]  awaddr = 10'h0, araddr = 10'h0;
    logic [2:0]  awprot = 3'b000, arprot = 3'b000;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [31:0] wdata = 32'h0;
    logic [3:0]  wstrb = 4'h0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic [32*NR-1:0] csr_data_o;
    logic [NI-1:0]    in_v_o;
    logic [32*NI-1:0] in_data_o;
    logic [NI-1:0]    in_yumi_i = '0;
    logic [NO-1:0]    out_v_i = '0;
    logic [32*NO-1:0] out_data_i = '0;
    logic [NO-1:0]    out_ready_o;

    typedef struct packed { logic [31:0] data; logic [1:0] resp; } rd_exp_t;
    logic [1:0]  exp_b_q [$];
    rd_exp_t     exp_r_q [$];
    logic [31:0] exp_out_q [$];
    int passed = 0, total = 0;

    axil_fifo_csr_shell #(
        .num_regs_p(NR), .num_in_fifos_p(NI), .num_out_fifos_p(NO), .fifo_els_p(ELS),
        .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(10)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .csr_data_o(csr_data_o), .in_v_o(in_v_o), .in_data_o(in_data_o), .in_yumi_i(in_yumi_i),
        .out_v_i(out_v_i), .out_data_i(out_data_i), .out_ready_o(out_ready_o)
    );

    always #5 aclk = ~aclk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Bus driver: full write transaction; resp is X if the DUT never answers
    task automatic do_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp);
        int n;
        @(posedge aclk); #1;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; #1;
        n = 0;
        while (!(awready && wready) && n < 50) begin @(posedge aclk); #1; n++; end
        @(posedge aclk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 50) begin @(posedge aclk); #1; n++; end
        resp = bvalid ? bresp : 2'bxx;
        bready = 1'b1;
        @(posedge aclk); #1;
        bready = 1'b0;
    endtask

    // Bus driver: full read transaction; data/resp are X if the DUT never answers
    task automatic do_read(input logic [9:0] a, output logic [31:0] data, output logic [1:0] resp);
        int n;
        @(posedge aclk); #1;
        araddr = a; arvalid = 1'b1; #1;
        n = 0;
        while (!arready && n < 50) begin @(posedge aclk); #1; n++; end
        @(posedge aclk); #1;
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 50) begin @(posedge aclk); #1; n++; end
        data = rvalid ? rdata : 32'hxxxx_xxxx;
        resp = rvalid ? rresp : 2'bxx;
        rready = 1'b1;
        @(posedge aclk); #1;
        rready = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        #1 aresetn = 1'b1;
        #1;
        total++; if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) $display("FAIL rst_hs got=%b exp=00000", {awready, wready, arready, bvalid, rvalid}); else passed++;
        total++; if ({bresp, rresp} !== 4'b0) $display("FAIL rst_resp got=%b exp=0000", {bresp, rresp}); else passed++;
        total++; if (rdata !== 32'h0) $display("FAIL rst_rdata got=%h exp=0", rdata); else passed++;
        total++; if (in_v_o !== 2'b00) $display("FAIL rst_in_v got=%b exp=00", in_v_o); else passed++;
        total++; if (out_ready_o !== 2'b11) $display("FAIL rst_out_ready got=%b exp=11", out_ready_o); else passed++;
        total++; if (csr_data_o !== '0) $display("FAIL rst_csr got=%h exp=0", csr_data_o); else passed++;
    endtask

    task automatic test_csr();
        logic [1:0] b, r; logic [31:0] d; rd_exp_t e; logic [1:0] eb;
        exp_b_q.push_back(2'b00);
        do_write(10'h304, 32'hA5A5_1234, 4'b0011, b);
        eb = exp_b_q.pop_front();
        total++; if (b !== eb) $display("FAIL csr_wr bresp got=%b exp=%b", b, eb); else passed++;
        exp_r_q.push_back('{data: 32'h0000_1234, resp: 2'b00});
        do_read(10'h304, d, r);
        e = exp_r_q.pop_front();
        total++; if ({d, r} !== {e.data, e.resp}) $display("FAIL csr_rd got=%h/%b exp=%h/%b", d, r, e.data, e.resp); else passed++;
        total++; if (csr_data_o[63:32] !== 32'h0000_1234) $display("FAIL csr_out got=%h exp=00001234", csr_data_o[63:32]); else passed++;
        exp_b_q.push_back(2'b00);
        do_write(10'h300, 32'hCAFE_F00D, 4'hF, b);
        eb = exp_b_q.pop_front();
        total++; if ({b, csr_data_o[31:0]} !== {eb, 32'hCAFE_F00D}) $display("FAIL csr0_wr got=%b/%h exp=%b/cafef00d", b, csr_data_o[31:0], eb); else passed++;
    endtask

    task automatic test_in_fifo();
        logic [1:0] b, r; logic [31:0] d; rd_exp_t e; logic [1:0] eb;
        for (int k = 0; k < 5; k++) begin
            exp_b_q.push_back((k < ELS) ? 2'b00 : 2'b10);
            do_write(10'h004, 32'h11 * (k + 1), 4'hF, b);
            eb = exp_b_q.pop_front();
            total++; if (b !== eb) $display("FAIL push%0d bresp got=%b exp=%b", k, b, eb); else passed++;
        end
        total++; if ({in_v_o, in_data_o[63:32]} !== {2'b10, 32'h11}) $display("FAIL in_head got=%b/%h exp=10/00000011", in_v_o, in_data_o[63:32]); else passed++;
        exp_r_q.push_back('{data: 32'd0, resp: 2'b00});
        exp_r_q.push_back('{data: 32'd4, resp: 2'b00});
        for (int k = 0; k < 2; k++) begin
            do_read((k == 0) ? 10'h004 : 10'h000, d, r);
            e = exp_r_q.pop_front();
            total++; if ({d, r} !== {e.data, e.resp}) $display("FAIL free%0d got=%h/%b exp=%h/%b", k, d, r, e.data, e.resp); else passed++;
        end
        @(posedge aclk); #1; in_yumi_i = 2'b10;
        @(posedge aclk); #1; in_yumi_i = 2'b00;
        total++; if ({in_v_o[1], in_data_o[63:32]} !== {1'b1, 32'h22}) $display("FAIL yumi_head got=%b/%h exp=1/00000022", in_v_o[1], in_data_o[63:32]); else passed++;
        exp_r_q.push_back('{data: 32'd1, resp: 2'b00});
        do_read(10'h004, d, r);
        e = exp_r_q.pop_front();
        total++; if ({d, r} !== {e.data, e.resp}) $display("FAIL free_after_yumi got=%h/%b exp=%h/%b", d, r, e.data, e.resp); else passed++;
    endtask

    task automatic test_out_fifo();
        logic [1:0] r; logic [31:0] d; rd_exp_t e;
        logic [9:0] addrs [4];
        addrs = '{10'h200, 10'h100, 10'h100, 10'h200};
        @(posedge aclk); #1; out_v_i = 2'b01; out_data_i[31:0] = 32'h0000_BEEF;
        @(posedge aclk); #1; out_v_i = 2'b00;
        exp_r_q.push_back('{data: 32'd1, resp: 2'b00});
        exp_r_q.push_back('{data: 32'h0000_BEEF, resp: 2'b00});
        exp_r_q.push_back('{data: 32'd0, resp: 2'b10});
        exp_r_q.push_back('{data: 32'd0, resp: 2'b00});
        for (int k = 0; k < 4; k++) begin
            do_read(addrs[k], d, r);
            e = exp_r_q.pop_front();
            total++; if ({d, r} !== {e.data, e.resp}) $display("FAIL out_rd%0d got=%h/%b exp=%h/%b", k, d, r, e.data, e.resp); else passed++;
        end
    endtask

    task automatic test_concurrency();
        logic [1:0] r; logic [31:0] d; rd_exp_t e;
        for (int k = 0; k < ELS; k++) begin
            @(posedge aclk); #1;
            out_v_i = 2'b01; out_data_i[31:0] = 32'hC0DE_0000 + k;
            exp_out_q.push_back(32'hC0DE_0000 + k);
        end
        @(posedge aclk); #1;
        out_data_i[31:0] = 32'hDEAD_DEAD;
        araddr = 10'h100; arvalid = 1'b1; #1;
        total++; if ({arready, out_ready_o[0]} !== 2'b10) $display("FAIL conc_edge got=%b exp=10", {arready, out_ready_o[0]}); else passed++;
        @(posedge aclk); #1;
        out_v_i = 2'b00; arvalid = 1'b0;
        total++; if (out_ready_o[0] !== 1'b1) $display("FAIL conc_ready_after got=%b exp=1", out_ready_o[0]); else passed++;
        d = exp_out_q.pop_front();
        total++; if ({rvalid, rdata, rresp} !== {1'b1, d, 2'b00}) $display("FAIL conc_pop got=%b/%h/%b exp=1/%h/00", rvalid, rdata, rresp, d); else passed++;
        rready = 1'b1; @(posedge aclk); #1; rready = 1'b0;
        exp_r_q.push_back('{data: ELS - 1, resp: 2'b00});
        do_read(10'h200, d, r);
        e = exp_r_q.pop_front();
        total++; if ({d, r} !== {e.data, e.resp}) $display("FAIL conc_count got=%h/%b exp=%h/%b", d, r, e.data, e.resp); else passed++;
        while (exp_out_q.size() > 0) begin
            exp_r_q.push_back('{data: exp_out_q.pop_front(), resp: 2'b00});
            do_read(10'h100, d, r);
            e = exp_r_q.pop_front();
            total++; if ({d, r} !== {e.data, e.resp}) $display("FAIL drain got=%h/%b exp=%h/%b", d, r, e.data, e.resp); else passed++;
        end
    endtask

    task automatic test_same_cycle();
        logic [1:0] b; rd_exp_t e; logic [1:0] eb;
        exp_b_q.push_back(2'b00);
        do_write(10'h308, 32'h1, 4'hF, b);
        eb = exp_b_q.pop_front();
        total++; if (b !== eb) $display("FAIL sc_pre bresp got=%b exp=%b", b, eb); else passed++;
        @(posedge aclk); #1;
        awaddr = 10'h308; wdata = 32'h2; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 10'h308; arvalid = 1'b1;
        exp_r_q.push_back('{data: 32'h1, resp: 2'b00});
        exp_b_q.push_back(2'b00);
        #1;
        total++; if ({awready, wready, arready} !== 3'b111) $display("FAIL sc_hs got=%b exp=111", {awready, wready, arready}); else passed++;
        @(posedge aclk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        e = exp_r_q.pop_front();
        eb = exp_b_q.pop_front();
        total++; if ({rvalid, rdata, rresp} !== {1'b1, e.data, e.resp}) $display("FAIL sc_rd got=%b/%h/%b exp=1/%h/%b", rvalid, rdata, rresp, e.data, e.resp); else passed++;
        total++; if ({bvalid, bresp} !== {1'b1, eb}) $display("FAIL sc_wr got=%b/%b exp=1/%b", bvalid, bresp, eb); else passed++;
        bready = 1'b1; rready = 1'b1;
        @(posedge aclk); #1;
        bready = 1'b0; rready = 1'b0;
        total++; if (csr_data_o[95:64] !== 32'h2) $display("FAIL sc_csr got=%h exp=00000002", csr_data_o[95:64]); else passed++;
    endtask

    task automatic test_backpressure();
        logic [1:0] b, r; logic [31:0] d; rd_exp_t e; logic [1:0] eb;
        int n;
        @(posedge aclk); #1;
        awaddr = 10'h104; wdata = 32'h5555_5555; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        exp_b_q.push_back(2'b10);
        #1; n = 0;
        while (!awready && n < 50) begin @(posedge aclk); #1; n++; end
        @(posedge aclk); #1;
        awaddr = 10'h300; wdata = 32'h0BAD_0BAD;
        eb = exp_b_q.pop_front();
        for (int k = 0; k < 5; k++) begin
            #1;
            total++; if ({bvalid, bresp} !== {1'b1, eb}) $display("FAIL bp_hold%0d got=%b/%b exp=1/%b", k, bvalid, bresp, eb); else passed++;
            total++; if (awready !== 1'b0) $display("FAIL bp_awready%0d got=%b exp=0", k, awready); else passed++;
            @(posedge aclk); #1;
        end
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        @(posedge aclk); #1;
        bready = 1'b0;
        total++; if ({bvalid, csr_data_o[31:0]} !== {1'b0, 32'hCAFE_F00D}) $display("FAIL bp_release got=%b/%h exp=0/cafef00d", bvalid, csr_data_o[31:0]); else passed++;
        exp_r_q.push_back('{data: 32'h0, resp: 2'b10});
        exp_r_q.push_back('{data: 32'h0, resp: 2'b10});
        for (int k = 0; k < 2; k++) begin
            do_read((k == 0) ? 10'h3FC : 10'h008, d, r);
            e = exp_r_q.pop_front();
            total++; if ({d, r} !== {e.data, e.resp}) $display("FAIL err_rd%0d got=%h/%b exp=%h/%b", k, d, r, e.data, e.resp); else passed++;
        end
        exp_b_q.push_back(2'b10);
        do_write(10'h208, 32'hFFFF_FFFF, 4'hF, b);
        eb = exp_b_q.pop_front();
        total++; if (b !== eb) $display("FAIL err_wr got=%b exp=%b", b, eb); else passed++;
    endtask

    task automatic test_reset_midop();
        logic [1:0] b, r; logic [31:0] d; int n;
        do_write(10'h000, 32'h55, 4'hF, b);
        @(posedge aclk); #1; out_v_i = 2'b10; out_data_i[63:32] = 32'h77;
        @(posedge aclk); #1; out_v_i = 2'b00;
        awaddr = 10'h30C; wdata = 32'h1234_5678; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        #1; n = 0;
        while (!awready && n < 50) begin @(posedge aclk); #1; n++; end
        @(posedge aclk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        total++; if ({bvalid, in_v_o[0], out_ready_o} !== 4'b1111) $display("FAIL mid_pre got=%b exp=1111", {bvalid, in_v_o[0], out_ready_o}); else passed++;
        aresetn = 1'b0;
        @(posedge aclk); #1;
        total++; if (bvalid !== 1'b0) $display("FAIL mid_bvalid got=%b exp=0", bvalid); else passed++;
        total++; if ({in_v_o, out_ready_o} !== 4'b0011) $display("FAIL mid_fifos got=%b exp=0011", {in_v_o, out_ready_o}); else passed++;
        total++; if (csr_data_o !== '0) $display("FAIL mid_csr got=%h exp=0", csr_data_o); else passed++;
        aresetn = 1'b1;
        bready = 1'b1;
        repeat (3) @(posedge aclk);
        #1 bready = 1'b0;
        total++; if (bvalid !== 1'b0) $display("FAIL mid_no_resp got=%b exp=0", bvalid); else passed++;
        do_read(10'h204, d, r);
        total++; if ({d, r} !== {32'h0, 2'b00}) $display("FAIL mid_count got=%h/%b exp=0/00", d, r); else passed++;
    endtask

    initial begin
        test_reset();
        test_csr();
        test_in_fifo();
        test_out_fifo();
        test_concurrency();
        test_same_cycle();
        test_backpressure();
        test_reset_midop();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
